// File: rtl/pwm_multi_ch.sv
// N-channel PWM generator with prescaler, programmable period, edge/center modes
// and shadowed duty registers. Optional output polarity: define PWM_POLARITY_EN.
module pwm_multi_ch #(
    parameter int NCH     = 3,
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 8,
    parameter int CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 mode,
    input  logic [PRESC_W-1:0]   presc,
    input  logic [WIDTH-1:0]     period,
    input  logic                 wr,
    input  logic [CH_W-1:0]      wr_ch,
    input  logic [WIDTH-1:0]     wr_val,
`ifdef PWM_POLARITY_EN
    input  logic [NCH-1:0]       pol,
`endif
    output logic [NCH-1:0]       pwm,
    output logic [WIDTH-1:0]     count_out,
    output logic [NCH*WIDTH-1:0] duty_flat,
    output logic [NCH-1:0]       pending,
    output logic                 period_tick
);

    // Counter direction is the only sequencing state; count_out exposes the rest.
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    logic [PRESC_W-1:0] pc;
    logic [WIDTH-1:0]   cnt;
    logic [WIDTH-1:0]   period_act;
    logic               mode_act;
    dir_t               dir;
    logic [WIDTH-1:0]   shadow [NCH];
    logic [WIDTH-1:0]   active [NCH];
`ifdef PWM_POLARITY_EN
    logic [NCH-1:0]     pol_act;
`endif

    logic               tick;
    logic               at_end;
    logic               boundary;
    logic               reload;
    logic [NCH-1:0]     wr_mask;
    logic [NCH-1:0]     cmp;

    // Write port: wr is a single-cycle strobe with no ready; the block always
    // accepts it, and an out-of-range wr_ch matches no channel and is dropped.
    always_comb begin
        tick = en && (pc == presc);
        if (!mode_act) begin
            at_end = (cnt == period_act);
        end else begin
            // P==1 turns around at cnt==1 while still going up.
            at_end = (period_act == '0) ||
                     ((cnt == WIDTH'(1)) && ((dir == DIR_DOWN) || (period_act == WIDTH'(1))));
        end
        boundary = tick && at_end;
        reload   = boundary || !en;
        wr_mask  = '0;
        cmp      = '0;
        for (int i = 0; i < NCH; i++) begin
            wr_mask[i] = wr && (wr_ch == CH_W'(i));
            cmp[i]     = (cnt < active[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= '0;
            cnt         <= '0;
            dir         <= DIR_UP;
            period_tick <= 1'b0;
        end else if (!en) begin
            pc          <= '0;
            cnt         <= '0;
            dir         <= DIR_UP;
            period_tick <= 1'b0;
        end else begin
            period_tick <= boundary;
            if (tick) begin
                pc <= '0;
                if (boundary) begin
                    cnt <= '0;
                    dir <= DIR_UP;
                end else if (!mode_act) begin
                    cnt <= cnt + WIDTH'(1);
                end else if (dir == DIR_UP) begin
                    if (cnt == period_act) begin
                        dir <= DIR_DOWN;
                        cnt <= cnt - WIDTH'(1);
                    end else begin
                        cnt <= cnt + WIDTH'(1);
                    end
                end else begin
                    cnt <= cnt - WIDTH'(1);
                end
            end else begin
                pc <= pc + PRESC_W'(1);
            end
        end
    end

    // A write landing on a reload cycle keeps its pending bit: active takes the old shadow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NCH; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
            pending    <= '0;
            period_act <= '0;
            mode_act   <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (wr_mask[i]) shadow[i] <= wr_val;
                if (reload)     active[i] <= shadow[i];
            end
            pending <= (reload ? '0 : pending) | wr_mask;
            if (reload) begin
                period_act <= period;
                mode_act   <= mode;
            end
        end
    end

`ifdef PWM_POLARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pol_act <= '0;
            pwm     <= '0;
        end else begin
            if (reload) pol_act <= pol;
            pwm <= en ? (cmp ^ pol_act) : pol_act;
        end
    end
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm <= '0;
        end else begin
            pwm <= en ? cmp : '0;
        end
    end
`endif

    always_comb begin
        count_out = cnt;
        duty_flat = '0;
        for (int i = 0; i < NCH; i++) begin
            duty_flat[i*WIDTH +: WIDTH] = active[i];
        end
    end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Directed bench for pwm_multi_ch (NCH=3, WIDTH=8): table of PWM configurations
// measured over one period, plus sequences for shadow timing, reset and corners.
module tb_pwm_multi_ch;

    logic        clk;
    logic        rst;
    logic        en;
    logic        mode;
    logic [7:0]  presc;
    logic [7:0]  period;
    logic        wr;
    logic [1:0]  wr_ch;
    logic [7:0]  wr_val;
`ifdef PWM_POLARITY_EN
    logic [2:0]  pol;
`endif
    logic [2:0]  pwm;
    logic [7:0]  count_out;
    logic [23:0] duty_flat;
    logic [2:0]  pending;
    logic        period_tick;

    int tests_run = 0;
    int failures  = 0;

    pwm_multi_ch dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mode       (mode),
        .presc      (presc),
        .period     (period),
        .wr         (wr),
        .wr_ch      (wr_ch),
        .wr_val     (wr_val),
`ifdef PWM_POLARITY_EN
        .pol        (pol),
`endif
        .pwm        (pwm),
        .count_out  (count_out),
        .duty_flat  (duty_flat),
        .pending    (pending),
        .period_tick(period_tick)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       mode;
        logic [7:0] presc;
        logic [7:0] period;
        logic [7:0] d0, d1, d2;
        int         e0, e1, e2;
        int         len;
    } vec_t;

    vec_t vecs[5];

    // Driver tasks: inputs change and outputs are sampled on the falling edge
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic write_duty(input logic [1:0] ch, input logic [7:0] val);
        @(negedge clk);
        wr     = 1'b1;
        wr_ch  = ch;
        wr_val = val;
        @(negedge clk);
        wr     = 1'b0;
    endtask

    task automatic apply_cfg(input logic m, input logic [7:0] ps, input logic [7:0] p,
                             input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
        @(negedge clk);
        en     = 1'b0;
        mode   = m;
        presc  = ps;
        period = p;
        write_duty(2'd0, d0);
        write_duty(2'd1, d1);
        write_duty(2'd2, d2);
        @(negedge clk);
    endtask

    task automatic wait_tick(input string name);
        bit found = 1'b0;
        for (int n = 0; n < 5000 && !found; n++) begin
            @(negedge clk);
            if (period_tick) found = 1'b1;
        end
        if (!found) begin
            tests_run++;
            failures++;
            $display("FAIL %s: no period_tick within 5000 clk", name);
        end
    endtask

    int exp_center[16] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 3, 3, 2, 2, 1, 1};
    int hi[3];
    int ticks;

    initial begin
        rst = 1'b0; en = 1'b0; mode = 1'b0; presc = '0; period = '0;
        wr = 1'b0; wr_ch = '0; wr_val = '0;
`ifdef PWM_POLARITY_EN
        pol = '0;
`endif
        vecs[0] = '{1'b0, 8'd0, 8'd255, 8'd64, 8'd192, 8'd0,   64, 192,  0, 256};
        vecs[1] = '{1'b0, 8'd2, 8'd9,   8'd5,  8'd10,  8'd0,   15,  30,  0,  30};
        vecs[2] = '{1'b1, 8'd1, 8'd4,   8'd2,  8'd5,   8'd4,    6,  16, 14,  16};
        vecs[3] = '{1'b1, 8'd0, 8'd1,   8'd1,  8'd0,   8'd2,    1,   0,  2,   2};
        vecs[4] = '{1'b0, 8'd3, 8'd0,   8'd1,  8'd0,   8'd5,    4,   0,  4,   4};

        repeat (3) @(negedge clk);
        check("reset_pwm",       pwm,         3'b000);
        check("reset_count",     count_out,   8'd0);
        check("reset_duty_flat", duty_flat,   24'd0);
        check("reset_pending",   pending,     3'b000);
        check("reset_tick",      period_tick, 1'b0);
        rst = 1'b1;

        // Table: one full period per configuration
        for (int v = 0; v < 5; v++) begin
            apply_cfg(vecs[v].mode, vecs[v].presc, vecs[v].period, vecs[v].d0, vecs[v].d1, vecs[v].d2);
            check($sformatf("vec%0d_duty_flat", v), duty_flat, {vecs[v].d2, vecs[v].d1, vecs[v].d0});
            en = 1'b1;
            wait_tick($sformatf("vec%0d_start", v));
            hi = '{0, 0, 0};
            ticks = 0;
            for (int k = 0; k < vecs[v].len; k++) begin
                for (int c = 0; c < 3; c++) hi[c] += int'(pwm[c]);
                ticks += int'(period_tick);
                @(negedge clk);
            end
            check($sformatf("vec%0d_ch0_high", v), hi[0], vecs[v].e0);
            check($sformatf("vec%0d_ch1_high", v), hi[1], vecs[v].e1);
            check($sformatf("vec%0d_ch2_high", v), hi[2], vecs[v].e2);
            check($sformatf("vec%0d_ticks", v), ticks, 1);
            check($sformatf("vec%0d_next_tick", v), period_tick, 1'b1);
        end

        // Center-aligned count sequence and first-tick latency
        apply_cfg(1'b1, 8'd1, 8'd4, 8'd2, 8'd0, 8'd0);
        en = 1'b1;
        @(negedge clk);
        check("start_count_0", count_out, 8'd0);
        @(negedge clk);
        check("start_count_1", count_out, 8'd1);
        wait_tick("center_start");
        for (int k = 0; k < 16; k++) begin
            check($sformatf("center_cnt_%0d", k), count_out, exp_center[k]);
            check($sformatf("center_pwm_%0d", k), pwm[0], exp_center[(k + 15) % 16] < 2);
            @(negedge clk);
        end

        // Shadow write mid-period: old duty completes, new duty loads at boundary
        apply_cfg(1'b0, 8'd0, 8'd9, 8'd5, 8'd0, 8'd0);
        en = 1'b1;
        wait_tick("shadow_start");
        hi[0] = 0;
        for (int k = 0; k < 10; k++) begin
            hi[0] += int'(pwm[0]);
            if (k == 3) begin
                wr = 1'b1; wr_ch = 2'd0; wr_val = 8'd2;
            end
            if (k == 4) begin
                wr = 1'b0;
                check("shadow_pending_set", pending[0], 1'b1);
                check("shadow_active_old", duty_flat[7:0], 8'd5);
            end
            @(negedge clk);
        end
        check("shadow_old_high", hi[0], 5);
        check("shadow_tick", period_tick, 1'b1);
        check("shadow_active_new", duty_flat[7:0], 8'd2);
        check("shadow_pending_clr", pending[0], 1'b0);
        hi[0] = 0;
        for (int k = 0; k < 10; k++) begin
            hi[0] += int'(pwm[0]);
            @(negedge clk);
        end
        check("shadow_new_high", hi[0], 2);

        // Write on the boundary cycle: loads one period later
        repeat (9) @(negedge clk);
        check("bnd_count_top", count_out, 8'd9);
        wr = 1'b1; wr_ch = 2'd0; wr_val = 8'd7;
        @(negedge clk);
        wr = 1'b0;
        check("bnd_tick", period_tick, 1'b1);
        check("bnd_active_old", duty_flat[7:0], 8'd2);
        check("bnd_pending_kept", pending[0], 1'b1);
        repeat (10) @(negedge clk);
        check("bnd_tick2", period_tick, 1'b1);
        check("bnd_active_new", duty_flat[7:0], 8'd7);
        check("bnd_pending_clr", pending[0], 1'b0);

        // Asynchronous reset mid-period
        wr = 1'b1; wr_ch = 2'd1; wr_val = 8'd3;
        @(negedge clk);
        wr = 1'b0;
        @(negedge clk);
        check("pre_rst_pwm", pwm, 3'b001);
        check("pre_rst_pending", pending, 3'b010);
        #2 rst = 1'b0;
        #1;
        check("arst_pwm",       pwm,       3'b000);
        check("arst_count",     count_out, 8'd0);
        check("arst_pending",   pending,   3'b000);
        check("arst_duty_flat", duty_flat, 24'd0);
        @(negedge clk);
        en = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("arst_shadow_lost", duty_flat, 24'd0);

        // Out-of-range channel write is ignored
        write_duty(2'd0, 8'h11);
        write_duty(2'd3, 8'haa);
        repeat (2) @(negedge clk);
        check("badch_duty_flat", duty_flat, 24'h000011);
        check("badch_pending",   pending,   3'b000);

        // Center mode with P=0: every tick is a boundary
        apply_cfg(1'b1, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0);
        en = 1'b1;
        wait_tick("p0_start");
        for (int k = 0; k < 5; k++) begin
            check($sformatf("p0_tick_cnt_%0d", k), {period_tick, count_out}, 9'h100);
            @(negedge clk);
        end

`ifdef PWM_POLARITY_EN
        pol = 3'b101;
        en  = 1'b0;
        repeat (3) @(negedge clk);
        check("pol_idle", pwm, 3'b101);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule

// File: doc/pwm_multi_ch.md
Name: pwm_multi_ch

Overview:
Parametrised N-channel PWM generator, successor to the fixed 3-channel 8-bit pwm_top. Adds a prescaler, a programmable period and edge/center-aligned modes. Duty writes go to shadow registers that load glitch-free at the period boundary. Sits between the control/button logic (manual write path) and the PWM output pins.

Parameters:
NCH, 3, number of PWM channels (1..16)
WIDTH, 8, counter/duty/period width in bits
PRESC_W, 8, prescaler width in bits
CH_W, $clog2(NCH) (min 1), channel-select width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
en  in  1  run enable
mode  in  1  0 = edge-aligned, 1 = center-aligned
presc  in  PRESC_W  prescaler; counter steps every presc+1 clk
period  in  WIDTH  top count P
wr  in  1  duty write strobe, one clk
wr_ch  in  CH_W  channel index for write
wr_val  in  WIDTH  duty value for write
pwm  out  NCH  PWM outputs, registered
count_out  out  WIDTH  current counter value
duty_flat  out  NCH*WIDTH  active duties; channel i at [i*WIDTH +: WIDTH]
pending  out  NCH  shadow written, not yet loaded
period_tick  out  1  one-clk pulse at period start

Behaviour:
- Reset (rst=0, async): all state cleared. Prescaler, counter, dir=up, active/shadow duty, period_act, mode_act and pending = 0; pwm = 0; period_tick = 0.
- Prescaler: pc counts 0..presc. tick = (pc==presc), then pc returns to 0. presc=0 gives a tick every clk.
- Edge mode: on each tick cnt goes 0,1..P,0. Boundary = the tick where cnt==P. Period is P+1 ticks.
- Center mode: on each tick cnt goes 0,1..P,P-1..1,0,1.. using a dir flag. Boundary = the tick where cnt==1 and dir=down (next cnt=0). Period is 2P ticks. If P=0, cnt stays 0 and every tick is a boundary.
- At a boundary:
  - active[i] <= shadow[i] for all i.
  - period_act <= period; mode_act <= mode.
  - pending cleared.
  - Counter next = 0, dir = up.
  - period_tick = 1 on the following clk, coincident with count_out==0.
- Counter, direction and boundaries use period_act and mode_act only. Changes to the period or mode inputs therefore never cut a period short.
- pwm[i] <= (cnt < active[i]) when en=1. Output lags count_out by 1 clk.
  - duty=0 gives constant low.
  - Edge mode: duty > P gives constant high.
  - Center mode: duty > P gives high except nothing; output is symmetric about cnt=P.
- Write: wr=1 with wr_ch < NCH sets shadow[wr_ch] <= wr_val and pending[wr_ch] <= 1. wr_ch >= NCH is ignored.
- Write coinciding with a boundary: active loads the OLD shadow. The new value stays in shadow with pending=1 until the next boundary.
- en=0:
  - pc, cnt and dir held at 0/up; pwm = 0; period_tick = 0.
  - active <= shadow, period_act <= period and mode_act <= mode every clk (immediate update).
  - pending cleared, except for a channel written in that cycle.
- en 0->1: counting starts from cnt=0. The first tick occurs after presc+1 clk.
- Reset mid-period: immediate return to reset state; shadow values are lost.
- Arithmetic: all comparisons unsigned on WIDTH bits. The counter never exceeds period_act, so there is no overflow.

Optional Feature:
PWM_POLARITY_EN
- Defined: adds input pol (NCH bits). pol[i] is registered at the boundary (continuously while en=0). pwm[i] = compare XOR pol_act[i]. When en=0, pwm[i] = pol_act[i] (idle level follows polarity). pol_act resets to 0.
- Undefined: no pol port; outputs are active-high and idle low.

Test Plan:
- Edge mode, NCH=3, WIDTH=8, presc=0, P=255, en=1; write ch0=64, ch1=192 while en=0 -> ch0 high 64 of 256 clk, ch1 high 192 of 256, ch2 constant low; period_tick every 256 clk.
- Shadow timing: en=1, P=9, ch0=5; write ch0=2 mid-period -> pending[0]=1 until boundary; new 2-tick duty appears starting the cycle after count_out wraps to 0; no runt pulse.
- Write on the boundary cycle (cnt==P, tick) -> active keeps the old value for one more period; pending stays 1; loads at the next boundary.
- Center mode, P=4, duty=2, presc=1 -> count_out 0,0,1,1,2,2,3,3,4,4,3,3,2,2,1,1 repeating; pwm high while cnt<2 (symmetric); period 16 clk.
- Boundaries: duty=0 gives pwm constant 0; duty=P+1 (edge) gives constant 1; wr_ch=3 with NCH=3 leaves all shadows unchanged; P=0 center mode gives period_tick every tick.
- Async reset: drop rst mid-period without a clk edge -> pwm, count_out, pending and duty_flat read 0 immediately; PWM_POLARITY_EN build with pol=3'b101 -> idle outputs 3'b101 after en=0.
